// File: rtl/pulse_period_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_period_meter: measures high time and rise-to-rise period of edge pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module pulse_period_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rising_edge,
    input  logic             falling_edge,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             timeout,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             tmo_q,    tmo_d;
    logic             ovr_q,    ovr_d;

    logic             w_rise;
    logic             w_fall;
    logic             w_expired;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_inc;

    // Coincident rise and fall pulses are a glitch and qualify as neither edge.
    assign w_rise    = rising_edge & ~falling_edge;
    assign w_fall    = falling_edge & ~rising_edge;
    assign w_expired = (cnt_q >= CNT_TIMEOUT);
    assign w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        tmo_d    = 1'b0;
        w_load   = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    cnt_d = w_cnt_inc;
                    if (w_rise) begin
                        cnt_d = CNT_ONE;
                    end else if (w_fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = S_LOW;
                    end else if (w_expired) begin
                        tmo_d   = 1'b1;
                        state_d = S_ARM;
                        cnt_d   = CNT_ZERO;
                    end
                end
                S_LOW: begin
                    cnt_d = w_cnt_inc;
                    if (w_rise) begin
                        w_load  = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = S_HIGH;
                    end else if (w_expired) begin
                        tmo_d   = 1'b1;
                        state_d = S_ARM;
                        cnt_d   = CNT_ZERO;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // A new result always loads; overrun flags only when the old one was refused.
    always_comb begin
        valid_d  = valid_q;
        high_d   = high_q;
        period_d = period_q;
        ovr_d    = 1'b0;
        if (w_load) begin
            valid_d  = 1'b1;
            high_d   = hi_lat_q;
            period_d = cnt_q;
            ovr_d    = valid_q & ~meas_ready;
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            hi_lat_q <= CNT_ZERO;
            valid_q  <= 1'b0;
            high_q   <= CNT_ZERO;
            period_q <= CNT_ZERO;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            valid_q  <= valid_d;
            high_q   <= high_d;
            period_q <= period_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign meas_valid  = valid_q;
    assign meas_high   = high_q;
    assign meas_period = period_q;
    assign timeout     = tmo_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q == S_HIGH) || (state_q == S_LOW);

endmodule
`default_nettype wire
